// File: rtl/viterbi_acs_unit.sv
`default_nettype none
// ============================================================================
// Module   : viterbi_acs_unit
// Brief    : Add-compare-select stage for a K=3, rate-1/2 (7,5) Viterbi decoder.
//            Optional erasure input is enabled with the ACS_ERASURE_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module viterbi_acs_unit #(
    parameter int PM_W      = 6,
    parameter int INIT_PM   = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      rx_sym,
`ifdef ACS_ERASURE_EN
    input  logic [1:0]      in_erase,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      dec,
    output logic [1:0]      best_state,
    output logic [PM_W-1:0] best_pm,
    output logic            out_last
);

    localparam logic [PM_W-1:0]       c_init_pm  = PM_W'(INIT_PM);
    localparam logic [3:0][PM_W-1:0]  c_pm_reset = {c_init_pm, c_init_pm, c_init_pm, {PM_W{1'b0}}};
    localparam logic [15:0]           c_last_cnt = 16'(FRAME_LEN - 1);

    logic [3:0][PM_W-1:0] r_pm;
    logic [15:0]          r_cnt;

    logic [3:0][PM_W-1:0] w_cand0;
    logic [3:0][PM_W-1:0] w_cand1;
    logic [3:0][PM_W-1:0] w_sel;
    logic [3:0][PM_W-1:0] w_norm;
    logic [3:0]           w_dec;
    logic [1:0]           w_mask;
    logic                 w_all_hi;
    logic                 w_accept;
    logic                 w_frame_end;
    logic [1:0]           w_best_state;
    logic [PM_W-1:0]      w_best_pm;

`ifdef ACS_ERASURE_EN
    assign w_mask = in_erase;
`else
    assign w_mask = 2'b00;
`endif

    // Hamming distance of the unmasked bit positions, 0..2.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic [1:0] exp_sym,
                                                 input logic [1:0] mask);
        logic [1:0] x;
        x = (sym ^ exp_sym) & ~mask;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Next state ns = {u,b1}; predecessors are {b1,0} and {b1,1}.
    for (genvar ns = 0; ns < 4; ns++) begin : g_acs
        localparam int U  = ns / 2;
        localparam int B1 = ns % 2;
        localparam logic [1:0] c_exp0 = {1'(U ^ B1), 1'(U)};
        localparam logic [1:0] c_exp1 = {1'(U ^ B1 ^ 1), 1'(U ^ 1)};

        assign w_cand0[ns] = r_pm[2*B1]     + PM_W'(branch_metric(rx_sym, c_exp0, w_mask));
        assign w_cand1[ns] = r_pm[2*B1 + 1] + PM_W'(branch_metric(rx_sym, c_exp1, w_mask));
        assign w_dec[ns]   = w_cand1[ns] < w_cand0[ns];
        assign w_sel[ns]   = w_dec[ns] ? w_cand1[ns] : w_cand0[ns];
    end

    assign w_all_hi = w_sel[0][PM_W-1] & w_sel[1][PM_W-1] & w_sel[2][PM_W-1] & w_sel[3][PM_W-1];

    for (genvar i = 0; i < 4; i++) begin : g_norm
        assign w_norm[i] = w_all_hi ? {1'b0, w_sel[i][PM_W-2:0]} : w_sel[i];
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        w_best_state = 2'd0;
        w_best_pm    = w_norm[0];
        for (int i = 1; i < 4; i++) begin
            if (w_norm[i] < w_best_pm) begin
                w_best_state = 2'(i);
                w_best_pm    = w_norm[i];
            end
        end
    end

    assign w_frame_end = (r_cnt == c_last_cnt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pm       <= c_pm_reset;
            r_cnt      <= 16'd0;
            out_valid  <= 1'b0;
            dec        <= 4'd0;
            best_state <= 2'd0;
            best_pm    <= {PM_W{1'b0}};
            out_last   <= 1'b0;
        end else if (w_accept) begin
            out_valid  <= 1'b1;
            dec        <= w_dec;
            best_state <= w_best_state;
            best_pm    <= w_best_pm;
            out_last   <= w_frame_end;
            if (w_frame_end) begin
                r_cnt <= 16'd0;
                r_pm  <= c_pm_reset;
            end else begin
                r_cnt <= r_cnt + 16'd1;
                r_pm  <= w_norm;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_acs_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_viterbi_acs_unit
// Brief    : Directed plus random checks of viterbi_acs_unit against a
//            symbol-level trellis model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_acs_unit;

    localparam int PM_W      = 5;
    localparam int INIT_PM   = 8;
    localparam int FRAME_LEN = 100;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      rx_sym;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      dec;
    logic [1:0]      best_state;
    logic [PM_W-1:0] best_pm;
    logic            out_last;
`ifdef ACS_ERASURE_EN
    logic [1:0]      in_erase;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_pm[4];
    int m_cnt;
    int e_dec, e_bs, e_bpm, e_last;
    int m_drops, d_drops, prev_dut_bpm, prev_m_bpm;

    viterbi_acs_unit #(.PM_W(PM_W), .INIT_PM(INIT_PM), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rx_sym(rx_sym),
`ifdef ACS_ERASURE_EN
        .in_erase(in_erase),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .dec(dec),
        .best_state(best_state), .best_pm(best_pm), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int enc(input int u, input int b1, input int b2);
        return ((u ^ b1 ^ b2) << 1) | (u ^ b2);
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = INIT_PM;
        m_cnt = 0;
    endtask

    task automatic model_step(input int sym);
        int np[4];
        int c0, c1;
        int modv, half;
        modv  = 1 << PM_W;
        half  = 1 << (PM_W - 1);
        e_dec = 0;
        for (int ns = 0; ns < 4; ns++) begin
            c0 = (m_pm[2*(ns%2)]     + $countones(sym ^ enc(ns/2, ns%2, 0))) % modv;
            c1 = (m_pm[2*(ns%2) + 1] + $countones(sym ^ enc(ns/2, ns%2, 1))) % modv;
            if (c1 < c0) begin
                np[ns] = c1;
                e_dec  = e_dec | (1 << ns);
            end else begin
                np[ns] = c0;
            end
        end
        if (np[0] >= half && np[1] >= half && np[2] >= half && np[3] >= half)
            for (int i = 0; i < 4; i++) np[i] = np[i] - half;
        e_bs  = 0;
        e_bpm = np[0];
        for (int i = 1; i < 4; i++)
            if (np[i] < e_bpm) begin e_bs = i; e_bpm = np[i]; end
        m_cnt++;
        e_last = (m_cnt == FRAME_LEN) ? 1 : 0;
        if (e_last == 1) model_reset();
        else for (int i = 0; i < 4; i++) m_pm[i] = np[i];
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_dec"},   dec,        e_dec);
        chk({tag, "_bs"},    best_state, e_bs);
        chk({tag, "_bpm"},   best_pm,    e_bpm);
        chk({tag, "_last"},  out_last,   e_last);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one symbol, wait (bounded) for acceptance, then check the result.
    task automatic send(input int sym, input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        rx_sym   = 2'(sym);
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_step(sym);
        chk_out(tag);
    endtask

    initial begin
        int sym;
        int snap_dec, snap_bpm, snap_bs;
        int bs_seq[4];
        int lasts;
        bs_seq = '{2, 1, 2, 3};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rx_sym    = 2'b00;
        out_ready = 1'b1;
`ifdef ACS_ERASURE_EN
        in_erase  = 2'b00;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_dec", dec, 0);
        chk("rst_bs", best_state, 0);
        chk("rst_bpm", best_pm, 0);
        chk("rst_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // First symbol after reset
        send(0, "first");
        chk("first_dec_const", dec, 0);
        chk("first_bpm_const", best_pm, 0);
        @(posedge clk);
        #1;
        chk("valid_clears", out_valid, 0);

        // Sixteen zeros at full throughput
        for (int i = 0; i < 16; i++) begin
            send(0, "zeros");
            chk("zeros_bs_const", best_state, 0);
            chk("zeros_bpm_const", best_pm, 0);
            chk("zeros_in_ready", in_ready, 1);
        end

        // Error-free encoded input bits 1,0,1,1
        do_reset();
        send(3, "enc0"); chk("enc0_bs_const", best_state, bs_seq[0]); chk("enc0_bpm0", best_pm, 0);
        send(2, "enc1"); chk("enc1_bs_const", best_state, bs_seq[1]); chk("enc1_bpm0", best_pm, 0);
        send(0, "enc2"); chk("enc2_bs_const", best_state, bs_seq[2]); chk("enc2_bpm0", best_pm, 0);
        send(1, "enc3"); chk("enc3_bs_const", best_state, bs_seq[3]); chk("enc3_bpm0", best_pm, 0);

        // Same sequence with one bit error in the third symbol
        do_reset();
        send(3, "err0");
        send(2, "err1");
        send(1, "err2"); chk("err2_bpm1", best_pm, 1);
        send(1, "err3"); chk("err3_bpm1", best_pm, 1);

        // Backpressure: outputs frozen, queued symbol taken on release edge
        send(2, "hold_pre");
        snap_dec = dec; snap_bpm = best_pm; snap_bs = best_state;
        out_ready = 1'b0;
        rx_sym    = 2'b01;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_dec", dec, snap_dec);
            chk("hold_bpm", best_pm, snap_bpm);
            chk("hold_bs", best_state, snap_bs);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_step(1);
        chk_out("release");

        // Random symbols
        for (int i = 0; i < 40; i++) begin
            sym = int'($urandom_range(0, 3));
            send(sym, "rand");
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        // Reset while an output is pending
        send(3, "pend");
        out_ready = 1'b0;
        do_reset();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_bpm", best_pm, 0);
        chk("midrst_dec", dec, 0);
        chk("midrst_last", out_last, 0);
        out_ready = 1'b1;

        // Frame boundary: out_last only on symbol FRAME_LEN, then fresh frame
        lasts = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            sym = int'($urandom_range(0, 3));
            send(sym, "frame");
            if (out_last) lasts++;
        end
        chk("frame_last_at_end", out_last, 1);
        chk("frame_last_count", lasts, 1);
        send(0, "frame_next");
        chk("frame_next_last", out_last, 0);
        chk("frame_next_dec_const", dec, 0);
        chk("frame_next_bpm_const", best_pm, 0);

        // Constant 11 input drives the metrics into normalization
        do_reset();
        m_drops = 0; d_drops = 0; prev_dut_bpm = 0; prev_m_bpm = 0;
        for (int i = 0; i < 90; i++) begin
            send(3, "norm");
            if (e_bpm < prev_m_bpm) m_drops++;
            if (int'(best_pm) < prev_dut_bpm) d_drops++;
            prev_m_bpm   = e_bpm;
            prev_dut_bpm = int'(best_pm);
        end
        chk("norm_drop_count", d_drops, m_drops);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/viterbi_acs_unit.md
Name: viterbi_acs_unit

Overview:
- Add-compare-select stage of the Viterbi decoder: the consumer of the 2-bit received-vs-expected symbol XOR distance.
- Takes one received 2-bit code symbol per handshake and computes branch metrics internally (2-bit XOR plus popcount).
- Updates four path metrics for the K=3, rate-1/2, (7,5) octal trellis.
- Emits per-state survivor decision bits and the best state to the downstream traceback stage.

Parameters:
- PM_W, 6, path metric width in bits; must be at least 5.
- INIT_PM, 16, reset and frame-start metric for states 1..3; must be below 2^(PM_W-1)-2.
- FRAME_LEN, 64, symbols per frame; range 2..65535.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  rx_sym valid
- in_ready  output  1  unit can accept a symbol
- rx_sym  input  2  received code symbol {g0,g1}
- out_valid  output  1  decision word valid
- out_ready  input  1  downstream accepts the decision word
- dec  output  4  survivor bit per next state; dec[i] belongs to state i
- best_state  output  2  state holding the minimum new metric
- best_pm  output  PM_W  that minimum metric
- out_last  output  1  marks the last symbol of a frame

Behaviour:
- Reset: one clock, synchronous, active-low (rst_n sampled on the rising edge of clk).
- Values forced by rst_n=0: pm[0]=0, pm[1..3]=INIT_PM, out_valid=0, dec=0, best_state=0, best_pm=0, out_last=0, symbol counter=0.
- in_ready is combinational: !out_valid || out_ready. It is therefore 1 out of reset.
- Accept: in_valid && in_ready at a rising edge. Results are registered on that same edge, so out_valid=1 the following cycle (latency 1). Full throughput when out_ready is held high.
- Output hold: while out_valid && !out_ready, all outputs and pm stay unchanged and no symbol is accepted.
- out_valid clears on the handshake edge unless a new symbol is accepted on the same edge.
- State encoding: state = {b1,b2}, where b1 is the previous input bit. Next state = {u,b1}.
- Expected symbol for a transition: {u^b1^b2, u^b2}.
- Branch metric: popcount(rx_sym ^ expected), range 0..2.
- ACS for next state ns, with u=ns[1] and b1=ns[0]:
  - candidates m0 = pm[{b1,0}] + bm0 and m1 = pm[{b1,1}] + bm1, both PM_W-bit unsigned;
  - choose m1 only if m1 < m0, so ties go to m0;
  - dec[ns] = 1 when m1 is chosen.
- Best state: minimum new metric; on equal metrics the lowest index wins.
- Normalization: if all four new metrics have their MSB set, subtract 2^(PM_W-1) from each before storing. best_pm reports the stored (normalized) value.
- Frame counter:
  - increments on each accept;
  - the accept that makes the count FRAME_LEN sets out_last=1 with that result and returns the counter to 0;
  - the same edge reloads pm to the reset values;
  - the next symbol therefore starts a fresh frame.
- Reset mid-frame: rst_n=0 discards pm, the counter and any pending output on that edge. A pending out_valid drops with no handshake.

Optional Feature:
- Macro: ACS_ERASURE_EN.
- Defined:
  - adds input in_erase [1:0], sampled with rx_sym;
  - a set bit removes that bit position from both branch metrics (used for punctured or erased bits);
  - in_erase=2'b11 gives bm=0 on every branch, so pm is unchanged apart from normalization.
- Undefined: the port is absent and all bits contribute to the metric.

Test Plan:
- Reset, then one accept of rx_sym=00 with out_ready=1 -> next cycle out_valid=1, dec=0000, best_state=0, best_pm=0; internal pm={0,17,2,17}.
- Sixteen consecutive 00 symbols at full throughput -> out_valid high every cycle, best_state=0 and best_pm=0 throughout, in_ready always 1.
- Encode input bits 1,0,1,1 (channel symbols 11,10,00,01) error-free -> best_pm=0 at every output and best_state sequence 2,1,2,3. Then flip one bit of symbol 2 -> best_pm=1 from that symbol onward.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs frozen, no symbol consumed. Release -> the queued symbol is accepted on the release edge.
- FRAME_LEN=4, 5 symbols -> out_last=1 only on output 4; output 5 matches the post-reset first-symbol result.
- Drive rx_sym=11 continuously with PM_W=5 until normalization occurs -> no metric wraps, and all four metrics drop by 16 in a single cycle.
